// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: FSM states, instruction
// field encodings, branch condition codes and datapath select encodings.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_FETCH   = 2'b00,
      S_DECODE  = 2'b01,
      S_EXEC    = 2'b10,
      S_LOAD_WB = 2'b11
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_MEM   = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_SHIFT = 4'b1000;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_MOV   = 4'b1101;
   localparam logic [3:0] EXT_LSH   = 4'b0100;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] CC_EQ    = 4'b0000;
   localparam logic [3:0] CC_NE    = 4'b0001;
   localparam logic [3:0] CC_CS    = 4'b0010;
   localparam logic [3:0] CC_CC    = 4'b0011;
   localparam logic [3:0] CC_L     = 4'b0100;
   localparam logic [3:0] CC_NL    = 4'b0101;
   localparam logic [3:0] CC_N     = 4'b0110;
   localparam logic [3:0] CC_NN    = 4'b0111;
   localparam logic [3:0] CC_F     = 4'b1000;
   localparam logic [3:0] CC_NF    = 4'b1001;
   localparam logic [3:0] CC_HI    = 4'b1010;
   localparam logic [3:0] CC_LS    = 4'b1011;
   localparam logic [3:0] CC_GT    = 4'b1100;
   localparam logic [3:0] CC_LE    = 4'b1101;
   localparam logic [3:0] CC_UC    = 4'b1110;
   localparam logic [3:0] CC_NEVER = 4'b1111;

   // Bit positions inside the {C,L,F,Z,N} flag vector
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   localparam logic [1:0] PC_SEL_INC  = 2'b00;
   localparam logic [1:0] PC_SEL_DISP = 2'b01;
   localparam logic [1:0] PC_SEL_REG  = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC  = 2'b10;

   function automatic logic is_imm_alu(input logic [3:0] op);
      logic r_hit;
      case (op)
         OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
         OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI: r_hit = 1'b1;
         default:                           r_hit = 1'b0;
      endcase
      return r_hit;
   endfunction

endpackage

// File: rtl/cond_check.sv
// Branch/jump condition evaluator: maps the 4-bit condition code carried in the
// Rdest field onto the current {C,L,F,Z,N} flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] Rdest,
   input  logic [4:0] flags,
   output logic       cond
);

   logic w_c, w_l, w_f, w_z, w_n;

   assign w_c = flags[FLAG_C];
   assign w_l = flags[FLAG_L];
   assign w_f = flags[FLAG_F];
   assign w_z = flags[FLAG_Z];
   assign w_n = flags[FLAG_N];

   // Condition-code lookup
   always_comb begin
      case (Rdest)
         CC_EQ:    cond = w_z;
         CC_NE:    cond = ~w_z;
         CC_CS:    cond = w_c;
         CC_CC:    cond = ~w_c;
         CC_L:     cond = w_l;
         CC_NL:    cond = ~w_l;
         CC_N:     cond = w_n;
         CC_NN:    cond = ~w_n;
         CC_F:     cond = w_f;
         CC_NF:    cond = ~w_f;
         CC_HI:    cond = ~w_l & ~w_z;
         CC_LS:    cond = w_l | w_z;
         CC_GT:    cond = ~w_n & ~w_z;
         CC_LE:    cond = w_n | w_z;
         CC_UC:    cond = 1'b1;
         CC_NEVER: cond = 1'b0;
         default:  cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM (fetch, decode, execute, load write-back).
// Outputs are decoded combinationally from the current state and the IR fields.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic [3:0] opcode,
   input  logic [3:0] opcodeExt_ImmHi,
   input  logic [3:0] Rdest,
   input  logic [4:0] flags,
   output logic       ir_en,
   output logic       pc_en,
   output logic [1:0] pc_sel,
   output logic       addr_sel,
   output logic       mem_we,
   output logic       regfile_we,
   output logic       flags_we,
   output logic [1:0] wb_sel,
   output logic       alu_src_imm
);

   state_t     r_state;
   state_t     w_next_state;
   logic       w_cond;

   logic       w_x_pc_en, w_x_addr_sel, w_x_mem_we, w_x_regfile_we;
   logic       w_x_flags_we, w_x_alu_src_imm, w_x_is_load;
   logic [1:0] w_x_pc_sel, w_x_wb_sel;

   logic       w_ir_en, w_pc_en, w_addr_sel, w_mem_we, w_regfile_we;
   logic       w_flags_we, w_alu_src_imm;
   logic [1:0] w_pc_sel, w_wb_sel;

   cond_check u_cond_check (
      .Rdest (Rdest),
      .flags (flags),
      .cond  (w_cond)
   );

   // State register; reset wins over stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else if (stall) begin
         r_state <= r_state;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Execute-phase instruction decode
   always_comb begin
      w_x_pc_en       = 1'b1;
      w_x_pc_sel      = PC_SEL_INC;
      w_x_addr_sel    = 1'b0;
      w_x_mem_we      = 1'b0;
      w_x_regfile_we  = 1'b0;
      w_x_flags_we    = 1'b0;
      w_x_wb_sel      = WB_SEL_ALU;
      w_x_alu_src_imm = 1'b0;
      w_x_is_load     = 1'b0;
      if (opcode == OP_RTYPE) begin
         w_x_regfile_we = (opcodeExt_ImmHi != EXT_CMP);
         w_x_flags_we   = (opcodeExt_ImmHi != EXT_MOV);
      end else if (is_imm_alu(opcode)) begin
         w_x_alu_src_imm = 1'b1;
         w_x_regfile_we  = (opcode != OP_CMPI);
         w_x_flags_we    = (opcode != OP_MOVI) && (opcode != OP_LUI);
      end else if (opcode == OP_SHIFT) begin
         w_x_regfile_we  = 1'b1;
         w_x_alu_src_imm = (opcodeExt_ImmHi != EXT_LSH);
      end else if (opcode == OP_MEM) begin
         case (opcodeExt_ImmHi)
            EXT_LOAD: begin
               // PC holds until the write-back cycle completes the load
               w_x_addr_sel = 1'b1;
               w_x_pc_en    = 1'b0;
               w_x_is_load  = 1'b1;
            end
            EXT_STOR: begin
               w_x_addr_sel = 1'b1;
               w_x_mem_we   = 1'b1;
            end
            EXT_JAL: begin
               w_x_regfile_we = 1'b1;
               w_x_wb_sel     = WB_SEL_PC;
               w_x_pc_sel     = PC_SEL_REG;
            end
            EXT_JCOND: begin
               w_x_pc_sel = w_cond ? PC_SEL_REG : PC_SEL_INC;
            end
            default: begin
               w_x_pc_en = 1'b1;
            end
         endcase
      end else if (opcode == OP_BCOND) begin
         w_x_pc_sel = w_cond ? PC_SEL_DISP : PC_SEL_INC;
      end else begin
         w_x_pc_en = 1'b1;
      end
   end

   // Next-state and per-state raw controls
   always_comb begin
      w_next_state  = r_state;
      w_ir_en       = 1'b0;
      w_pc_en       = 1'b0;
      w_pc_sel      = PC_SEL_INC;
      w_addr_sel    = 1'b0;
      w_mem_we      = 1'b0;
      w_regfile_we  = 1'b0;
      w_flags_we    = 1'b0;
      w_wb_sel      = WB_SEL_ALU;
      w_alu_src_imm = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            w_ir_en      = 1'b1;
            w_next_state = S_EXEC;
         end
         S_EXEC: begin
            w_pc_en       = w_x_pc_en;
            w_pc_sel      = w_x_pc_sel;
            w_addr_sel    = w_x_addr_sel;
            w_mem_we      = w_x_mem_we;
            w_regfile_we  = w_x_regfile_we;
            w_flags_we    = w_x_flags_we;
            w_wb_sel      = w_x_wb_sel;
            w_alu_src_imm = w_x_alu_src_imm;
            w_next_state  = w_x_is_load ? S_LOAD_WB : S_FETCH;
         end
         S_LOAD_WB: begin
            w_addr_sel   = 1'b1;
            w_regfile_we = 1'b1;
            w_wb_sel     = WB_SEL_MEM;
            w_pc_en      = 1'b1;
            w_pc_sel     = PC_SEL_INC;
            w_next_state = S_FETCH;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Output gating: reset clears everything, stall suppresses only the strobes
   always_comb begin
      if (reset) begin
         ir_en       = 1'b0;
         pc_en       = 1'b0;
         mem_we      = 1'b0;
         regfile_we  = 1'b0;
         flags_we    = 1'b0;
         pc_sel      = PC_SEL_INC;
         addr_sel    = 1'b0;
         wb_sel      = WB_SEL_ALU;
         alu_src_imm = 1'b0;
      end else begin
         ir_en       = w_ir_en      & ~stall;
         pc_en       = w_pc_en      & ~stall;
         mem_we      = w_mem_we     & ~stall;
         regfile_we  = w_regfile_we & ~stall;
         flags_we    = w_flags_we   & ~stall;
         pc_sel      = w_pc_sel;
         addr_sel    = w_addr_sel;
         wb_sel      = w_wb_sel;
         alu_src_imm = w_alu_src_imm;
      end
   end

endmodule
